// File: rtl/gray_to_bin_dec_if.sv
// Handshake bundle for the Gray-to-binary decoder.
// Input side:  in_valid/in_ready carry gray_in.
// Output side: out_valid/out_ready carry bin_out and step_err.
// A word moves only on a rising clk edge where valid and ready are both 1.
// valid never waits on ready, and the payload holds still while valid is 1
// and ready is 0.
interface gray_to_bin_dec_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] gray_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] bin_out;
    logic             step_err;

    // Producer/consumer side (testbench or surrounding logic)
    modport master (
        output in_valid, gray_in, out_ready,
        input  in_ready, out_valid, bin_out, step_err
    );

    // Decoder side
    modport slave (
        input  in_valid, gray_in, out_ready,
        output in_ready, out_valid, bin_out, step_err
    );
endinterface

// File: rtl/gray_to_bin_dec.sv
// gray_to_bin_dec: sequential Gray-to-binary decoder.
// The decoder takes one Gray word, then resolves it MSB-first over WIDTH cycles.
// It holds the binary result until the consumer takes it.
// Optional macro GRAY_STEP_CHECK_EN adds a step checker. The checker flags an
// accepted word that differs from the previous accepted word in more than one bit.
// o_dbg_state exposes the FSM state (IDLE=0, DECODE=1, HOLD=2).
module gray_to_bin_dec #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    gray_to_bin_dec_if.slave   bus,
    output logic [1:0]         o_dbg_state
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_gray;
    logic [IW-1:0]    r_idx;
    logic             r_prev_bit;
    logic [WIDTH-1:0] r_part;
    logic [WIDTH-1:0] r_bin_out;
    logic             w_bit;
    logic [WIDTH-1:0] w_part_next;
    logic             w_accept;
    logic             w_done;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_step_err;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                if (r_idx == '0) begin
                    w_done       = 1'b1;
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Resolve one bit.
    // b[i] = b[i+1] ^ g[i], and the bit above the MSB counts as 0.
    always_comb begin
        w_bit              = r_prev_bit ^ r_gray[r_idx];
        w_part_next        = r_part;
        w_part_next[r_idx] = w_bit;
    end

    // Working registers and the published result.
    // bin_out changes only when the last bit resolves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gray     <= '0;
            r_idx      <= IW'(WIDTH - 1);
            r_prev_bit <= 1'b0;
            r_part     <= '0;
            r_bin_out  <= '0;
        end else if (w_accept) begin
            r_gray     <= bus.gray_in;
            r_idx      <= IW'(WIDTH - 1);
            r_prev_bit <= 1'b0;
            r_part     <= '0;
        end else if (r_state == S_DECODE) begin
            r_part     <= w_part_next;
            r_prev_bit <= w_bit;
            if (w_done) begin
                r_bin_out <= w_part_next;
                r_idx     <= IW'(WIDTH - 1);
            end else begin
                r_idx <= r_idx - IW'(1);
            end
        end
    end

`ifdef GRAY_STEP_CHECK_EN
    logic [WIDTH-1:0] r_prev_gray;
    logic             r_prev_valid;
    logic             r_err_pend;
    logic             r_step_err;
    logic [WIDTH-1:0] w_diff;
    logic             w_multi_bit;

    // More than one differing bit: clearing the lowest set bit leaves something.
    always_comb begin
        w_diff      = bus.gray_in ^ r_prev_gray;
        w_multi_bit = ((w_diff & (w_diff - WIDTH'(1))) != '0);
    end

    // History and flag.
    // The flag is judged at accept and published with the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_gray  <= '0;
            r_prev_valid <= 1'b0;
            r_err_pend   <= 1'b0;
            r_step_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_err_pend   <= r_prev_valid & w_multi_bit;
                r_prev_gray  <= bus.gray_in;
                r_prev_valid <= 1'b1;
            end
            if (w_done) begin
                r_step_err <= r_err_pend;
            end
        end
    end

    assign w_step_err = r_step_err;
`else
    assign w_step_err = 1'b0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.bin_out   = r_bin_out;
    assign bus.step_err  = w_step_err;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_gray_to_bin_dec.sv
// Self-checking bench for gray_to_bin_dec (WIDTH=4).
// The reference model decodes by prefix-XOR of right shifts.
// It judges Gray steps with $countones.
module tb_gray_to_bin_dec;
    localparam int W      = 4;
    localparam int BUDGET = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    logic [W:0]   exp_q[$];
    logic [W-1:0] prev_gray;
    logic         prev_valid;

    gray_to_bin_dec_if #(.WIDTH(W)) bus ();

    gray_to_bin_dec #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b = '0;
        for (int k = 0; k < W; k++) b ^= (g >> k);
        return b;
    endfunction

    function automatic logic ref_step_err(input logic [W-1:0] g);
`ifdef GRAY_STEP_CHECK_EN
        return prev_valid && ($countones(g ^ prev_gray) > 1);
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_clear();
        prev_valid = 1'b0;
        prev_gray  = '0;
        exp_q.delete();
    endfunction

    // ---------------- drivers ----------------
    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.gray_in   = '0;
        tick();
        tick();
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic send_word(input logic [W-1:0] g, output int acc_cyc);
        int n;
        n = 0;
        while (!bus.in_ready && n < BUDGET) begin
            tick();
            n++;
        end
        if (!bus.in_ready) check_eq("in_ready_timeout", 0, 1);
        bus.in_valid = 1'b1;
        bus.gray_in  = g;
        tick();
        bus.in_valid = 1'b0;
        acc_cyc = cyc;
        exp_q.push_back({ref_step_err(g), ref_bin(g)});
        prev_gray  = g;
        prev_valid = 1'b1;
    endtask

    // Scoreboard side: wait for HOLD, check latency, compare against the queue
    task automatic wait_result(input int acc_cyc, input string tag);
        int n;
        logic [W:0] e;
        n = 0;
        while (!bus.out_valid && n < BUDGET) begin
            check_eq({tag, "_busy_in_ready"}, bus.in_ready, 0);
            tick();
            n++;
        end
        check_eq({tag, "_latency"}, cyc - acc_cyc, W);
        check_eq({tag, "_hold_in_ready"}, bus.in_ready, 0);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_exp_q_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_bin"}, bus.bin_out, e[W-1:0]);
            check_eq({tag, "_step_err"}, bus.step_err, e[W]);
        end
    endtask

    task automatic release_out(input int delay, input string tag);
        logic [W-1:0] held;
        held = bus.bin_out;
        for (int k = 0; k < delay; k++) begin
            tick();
            check_eq({tag, "_bp_valid"}, bus.out_valid, 1);
            check_eq({tag, "_bp_bin"}, bus.bin_out, held);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq({tag, "_after_release"}, bus.out_valid, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc;
        int last_acc;
        logic [W-1:0] g;
        logic [W-1:0] words2[3];
        logic [W-1:0] words4[3];
        logic [2:0]   step_exp;

        words2 = '{4'b0000, 4'b1000, 4'b0001};
        words4 = '{4'b0110, 4'b0111, 4'b0100};
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.gray_in   = '0;
        model_clear();

        // Reset state
        tick();
        check_eq("rst_in_ready", bus.in_ready, 1);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_bin_out", bus.bin_out, 0);
        check_eq("rst_step_err", bus.step_err, 0);
        check_eq("rst_state", dbg_state, 0);
        rst_n = 1'b1;

        // Single word 0110 -> 0100
        send_word(4'b0110, acc);
        wait_result(acc, "t1");
        check_eq("t1_bin_const", bus.bin_out, 4'b0100);
        release_out(0, "t1");

        // Back-to-back with out_ready tied high: spacing WIDTH+2
        bus.out_ready = 1'b1;
        last_acc = 0;
        for (int i = 0; i < 3; i++) begin
            send_word(words2[i], acc);
            if (i > 0) check_eq("t2_spacing", acc - last_acc, W + 2);
            last_acc = acc;
            wait_result(acc, "t2");
        end
        bus.out_ready = 1'b0;
        release_out(0, "t2");

        // Backpressure with an ignored in_valid pulse
        send_word(4'b1000, acc);
        wait_result(acc, "t3");
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                bus.in_valid = 1'b1;
                bus.gray_in  = 4'b0011;
            end
            tick();
            bus.in_valid = 1'b0;
            check_eq("t3_bp_out_valid", bus.out_valid, 1);
            check_eq("t3_bp_bin", bus.bin_out, 4'b1111);
            check_eq("t3_bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check_eq("t3_exit_state", dbg_state, 0);
        check_eq("t3_exit_in_ready", bus.in_ready, 1);
        check_eq("t3_exit_out_valid", bus.out_valid, 0);
        check_eq("t3_keep_bin", bus.bin_out, 4'b1111);

        // Step checker sequence after a fresh reset
        apply_reset();
`ifdef GRAY_STEP_CHECK_EN
        step_exp = 3'b100;
`else
        step_exp = 3'b000;
`endif
        for (int i = 0; i < 3; i++) begin
            send_word(words4[i], acc);
            wait_result(acc, "t4");
            check_eq("t4_step_const", bus.step_err, step_exp[i]);
            release_out(0, "t4");
        end

        // Asynchronous reset in the middle of a decode
        send_word(4'b1011, acc);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_in_ready", bus.in_ready, 1);
        check_eq("t5_rst_out_valid", bus.out_valid, 0);
        check_eq("t5_rst_bin", bus.bin_out, 0);
        check_eq("t5_rst_step", bus.step_err, 0);
        check_eq("t5_rst_state", dbg_state, 0);
        tick();
        rst_n = 1'b1;
        model_clear();
        send_word(4'b0011, acc);
        wait_result(acc, "t5");
        check_eq("t5_bin_const", bus.bin_out, 4'b0010);
        check_eq("t5_step_const", bus.step_err, 0);
        release_out(1, "t5");

        // Randomized words: mixes single-bit steps, repeats and jumps
        g = 4'b0011;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: g = g ^ (W'(1) << $urandom_range(0, W - 1));
                1: g = W'($urandom_range(0, (1 << W) - 1));
                default: g = g;
            endcase
            send_word(g, acc);
            wait_result(acc, "rnd");
            release_out($urandom_range(0, 3), "rnd");
        end

        check_eq("final_exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gray_to_bin_dec.md
# gray_to_bin_dec

Sequential Gray-to-binary decoder for the code-conversion library; the inverse of the 4-bit binary-to-Gray encoder. Accepts one Gray-coded word per valid/ready handshake, resolves the binary value bit-serially MSB-first over WIDTH cycles, then presents the result on a valid/ready output port. Sits between Gray-coded position/pointer sources and binary consumers. An optional step checker flags input words that differ from the previous accepted word in more than one bit.

## Interface
- WIDTH, 4, word width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  gray_in holds a word to accept
- in_ready  output  1  decoder can accept a word
- gray_in  input  WIDTH  Gray-coded input word
- out_valid  output  1  bin_out and step_err are valid
- out_ready  input  1  consumer takes the result
- bin_out  output  WIDTH  decoded binary word
- step_err  output  1  Gray step violation for the current result; constant 0 when the checker is compiled out

## Operation
- FSM states: IDLE, DECODE, HOLD.
- IDLE: in_ready=1. On a clock edge with in_valid=1, capture gray_in into the working register, set bit index i=WIDTH-1, clear the partial result, and go to DECODE.
- DECODE: in_ready=0. Each cycle resolves one bit: b[WIDTH-1]=g[WIDTH-1], then b[i]=b[i+1]^g[i], and i decrements. After bit 0 resolves, load bin_out and step_err and go to HOLD.
- HOLD: out_valid=1 and in_ready=0. bin_out and step_err stay stable. On an edge with out_ready=1, go to IDLE.
- in_valid is ignored outside IDLE. No word is accepted in HOLD, including the cycle in which out_ready is high.
- bin_out keeps the last result outside HOLD and is not updated mid-decode.
- Arithmetic: XOR only. No carries, and no width growth.

## Timing
- Reset (asynchronous, any state): state=IDLE, in_ready=1, out_valid=0, bin_out=0, step_err=0, i=WIDTH-1, checker history cleared. A partial decode is discarded. The first edge after deassertion may accept a word.
- Latency: word accepted at edge t0 -> out_valid=1 after edge t0+WIDTH. For WIDTH=4, out_valid rises 4 cycles after acceptance.
- Throughput: with out_ready tied high, one word per WIDTH+2 cycles (accept, WIDTH decode cycles, one HOLD cycle).
- Backpressure: out_valid stays high and outputs stay unchanged indefinitely while out_ready=0.
- out_ready=1 outside HOLD has no effect.

## Configuration
- GRAY_STEP_CHECK_EN defined:
  - Keep a WIDTH-bit prev_gray register and a prev_valid flag, both cleared by reset.
  - On each accept, compute the popcount of (gray_in ^ prev_gray). If prev_valid=1 and popcount>1, step_err=1 for that result; otherwise step_err=0.
  - 0 differing bits (repeated word) is legal.
  - After the compare, update prev_gray with gray_in and set prev_valid=1.
  - The first word after reset never flags.
- GRAY_STEP_CHECK_EN undefined: no history registers are built, and step_err is tied to 0.

## Test plan
- WIDTH=4, reset, then gray_in=0110 accepted at edge t0 -> out_valid=1 after edge t0+4, bin_out=0100; in_ready=0 from t0+1 until HOLD exits.
- gray_in sequence 0000, 1000, 0001, each drained with out_ready=1 -> bin_out 0000, 1111, 0001; measured spacing between accepts is 6 cycles.
- Backpressure: gray_in=1000 decoded, out_ready held 0 for 5 cycles -> out_valid stays 1, bin_out stays 1111, in_ready stays 0, and a pulse on in_valid is ignored; raising out_ready -> IDLE on the next edge.
- With GRAY_STEP_CHECK_EN, words 0110, 0111, 0100 -> bin_out 0100/0101/0111 with step_err 0/0/1. Without the macro, the same words give step_err 0/0/0.
- Async reset asserted two cycles into decoding 1011 -> outputs 0 immediately and in_ready=1. The next accepted word 0011 decodes to 0010 with step_err=0, since history was cleared.
